// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: turns a duty code into a MIN + code*STEP clock pulse once per fixed frame.
// Latency: one clock from frame counter to PwmOut/PeriodStart; a new code takes effect at the next frame boundary.
// Backpressure: none; DutyValid strobes are always accepted and the last strobe before a boundary wins.
module servo_pwm_gen #(
    parameter int unsigned DUTY_W        = 12,
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_CYCLES    = 50000,
    parameter int unsigned STEP_CYCLES   = 12,
    parameter int unsigned MAX_CODE      = 4095,
    parameter int unsigned RESET_CODE    = 2048
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              En,
    input  logic [DUTY_W-1:0] DutyIn,
    input  logic              DutyValid,
    output logic              PwmOut,
    output logic              PeriodStart,
    output logic [DUTY_W-1:0] DutyApplied,
    output logic              Clamped
);

    // Counter covers 0..PERIOD_CYCLES-1; the width register must also hold PERIOD_CYCLES itself.
    localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
    localparam int unsigned WID_W = $clog2(PERIOD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] CODE_MAX   = DUTY_W'(MAX_CODE);
    localparam logic [DUTY_W-1:0] CODE_RESET = DUTY_W'(RESET_CODE);
    localparam logic [WID_W-1:0]  WIDTH_RESET =
        WID_W'(MIN_CYCLES + RESET_CODE * STEP_CYCLES);

    // The widest pulse must leave at least one low clock in every frame.
    if (MIN_CYCLES + MAX_CODE * STEP_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
        $error("servo_pwm_gen: MIN_CYCLES + MAX_CODE*STEP_CYCLES must be below PERIOD_CYCLES");
    end

    // The post-reset code must itself be a legal, unclamped code.
    if (RESET_CODE > MAX_CODE) begin : g_bad_reset_code
        $error("servo_pwm_gen: RESET_CODE must not exceed MAX_CODE");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] pend_code;
    logic              pend_clamp;
    logic [WID_W-1:0]  width_reg;

    // Incoming code after clamping
    logic              in_clamp;
    logic [DUTY_W-1:0] in_code;

    // FSM outputs
    logic              run_en;
    logic              frame_start;

    // Code/width selected for a frame that starts this clock
    logic [DUTY_W-1:0] code_sel;
    logic              clamp_sel;
    logic [WID_W-1:0]  width_new;
    logic [WID_W-1:0]  width_eff;
    logic              pwm_nxt;

    // Clamp the incoming duty code to the servo's legal range.
    always_comb begin
        in_clamp = (32'(DutyIn) > MAX_CODE);
        in_code  = in_clamp ? CODE_MAX : DutyIn;
    end

    // FSM state register: IDLE while disabled, RUN while frames are being generated.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: enable alone moves between IDLE and RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (En)  state_nxt = S_RUN;
            S_RUN:   if (!En) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: a frame starts on the first enabled clock out of IDLE or when the counter wraps in RUN.
    always_comb begin
        run_en      = 1'b0;
        frame_start = 1'b0;
        case (state)
            S_IDLE: begin
                run_en      = En;
                frame_start = En;
            end
            S_RUN: begin
                run_en      = En;
                frame_start = En && (cnt == '0);
            end
            default: begin
                run_en      = 1'b0;
                frame_start = 1'b0;
            end
        endcase
    end

    // At a boundary a coincident strobe bypasses the pending register so it governs this very frame.
    always_comb begin
        code_sel  = DutyValid ? in_code  : pend_code;
        clamp_sel = DutyValid ? in_clamp : pend_clamp;
        width_new = WID_W'(MIN_CYCLES + 32'(code_sel) * STEP_CYCLES);
        width_eff = frame_start ? width_new : width_reg;
        pwm_nxt   = run_en && (WID_W'(cnt) < width_eff);
    end

    // Frame counter: free-runs 0..PERIOD_CYCLES-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            cnt <= '0;
        end else if (!run_en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pending register: every strobe is captured regardless of enable; the latest one wins.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            pend_code  <= CODE_RESET;
            pend_clamp <= 1'b0;
        end else if (DutyValid) begin
            pend_code  <= in_code;
            pend_clamp <= in_clamp;
        end
    end

    // Frame latch: applied code, clamp flag and pulse width change only at a frame boundary.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            DutyApplied <= CODE_RESET;
            Clamped     <= 1'b0;
            width_reg   <= WIDTH_RESET;
        end else if (frame_start) begin
            DutyApplied <= code_sel;
            Clamped     <= clamp_sel;
            width_reg   <= width_new;
        end
    end

    // Registered outputs: pulse high while counter is below the width, frame marker on the boundary clock.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            PwmOut      <= 1'b0;
            PeriodStart <= 1'b0;
        end else begin
            PwmOut      <= pwm_nxt;
            PeriodStart <= frame_start;
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a small frame (100 clocks) so whole frames can be measured.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// At a sample taken s clocks after a frame marker, the next rising edge processes counter value s+1.
module tb_servo_pwm_gen;

    logic       Clk;
    logic       Rest;
    logic       En;
    logic [5:0] DutyIn;
    logic       DutyValid;
    logic       PwmOut;
    logic       PeriodStart;
    logic [5:0] DutyApplied;
    logic       Clamped;

    int n_checks = 0;
    int n_fail   = 0;

    servo_pwm_gen #(
        .DUTY_W        (6),
        .PERIOD_CYCLES (100),
        .MIN_CYCLES    (10),
        .STEP_CYCLES   (1),
        .MAX_CODE      (50),
        .RESET_CODE    (20)
    ) dut (
        .Clk         (Clk),
        .Rest        (Rest),
        .En          (En),
        .DutyIn      (DutyIn),
        .DutyValid   (DutyValid),
        .PwmOut      (PwmOut),
        .PeriodStart (PeriodStart),
        .DutyApplied (DutyApplied),
        .Clamped     (Clamped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance falling edges until a frame marker is seen, with a bounded budget.
    task automatic wait_ps(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (PeriodStart === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    // Measure one frame starting at its marker sample; optionally strobe two codes at given sample offsets.
    task automatic run_frame(input int sa, input int va, input int sb, input int vb,
                             output int hi, output int ps, output int dapp, output int clmp);
        hi   = 0;
        ps   = 0;
        dapp = int'(DutyApplied);
        clmp = int'(Clamped);
        for (int s = 0; s < 100; s++) begin
            hi += int'(PwmOut);
            ps += int'(PeriodStart);
            if (s == sa) begin
                DutyValid = 1'b1;
                DutyIn    = 6'(va);
            end else if (s == sb) begin
                DutyValid = 1'b1;
                DutyIn    = 6'(vb);
            end else begin
                DutyValid = 1'b0;
            end
            @(negedge Clk);
        end
    endtask

    task automatic check_frame(input string tag, input int sa, input int va, input int sb, input int vb,
                               input int exp_hi, input int exp_dapp, input int exp_clmp);
        int hi, ps, dapp, clmp;
        run_frame(sa, va, sb, vb, hi, ps, dapp, clmp);
        chk({tag, "_width"},   32'(hi),   32'(exp_hi));
        chk({tag, "_markers"}, 32'(ps),   32'd1);
        chk({tag, "_applied"}, 32'(dapp), 32'(exp_dapp));
        chk({tag, "_clamped"}, 32'(clmp), 32'(exp_clmp));
        chk({tag, "_period"},  32'(PeriodStart), 32'd1);
    endtask

    initial begin
        int hi, ps;
        Rest      = 1'b1;
        En        = 1'b0;
        DutyIn    = '0;
        DutyValid = 1'b0;

        repeat (3) @(negedge Clk);
        chk("rst_pwm",     32'(PwmOut),      32'd0);
        chk("rst_ps",      32'(PeriodStart), 32'd0);
        chk("rst_applied", 32'(DutyApplied), 32'd20);
        chk("rst_clamped", 32'(Clamped),     32'd0);

        // Release reset with the generator enabled: the reset code governs the first frames.
        Rest = 1'b0;
        En   = 1'b1;
        wait_ps("start_marker");
        check_frame("f1", -1, 0, -1, 0, 30, 20, 0);
        // Strobe 5 at counter 40: this frame unchanged, next frame 10+5.
        check_frame("f2", 39, 5, -1, 0, 30, 20, 0);
        // Strobes 7 then 33 in one frame: the last wins, 10+33.
        check_frame("f3", 10, 7, 50, 33, 15, 5, 0);
        // Strobe 0 lands on the counter==0 edge of the next frame and governs it directly.
        check_frame("f4", 99, 0, -1, 0, 43, 33, 0);
        // Strobe 63 exceeds the maximum code 50.
        check_frame("f5", 20, 63, -1, 0, 10, 0, 0);
        check_frame("f6", 30, 10, -1, 0, 60, 50, 1);
        check_frame("f7", 40, 20, -1, 0, 20, 10, 0);

        // Frame of width 30; drop enable so the edge at counter 12 sees it low.
        chk("f8_applied", 32'(DutyApplied), 32'd20);
        hi = 0;
        for (int s = 0; s < 12; s++) begin
            hi += int'(PwmOut);
            if (s == 11) En = 1'b0;
            @(negedge Clk);
        end
        chk("f8_pre_drop_width", 32'(hi), 32'd12);
        hi = 0;
        ps = 0;
        repeat (20) begin
            hi += int'(PwmOut);
            ps += int'(PeriodStart);
            @(negedge Clk);
        end
        chk("idle_pwm_high",  32'(hi), 32'd0);
        chk("idle_markers",   32'(ps), 32'd0);

        // Re-enable: fresh full frame; strobe 40 for the following frame.
        En = 1'b1;
        wait_ps("reenable_marker");
        check_frame("re", 5, 40, -1, 0, 30, 20, 0);

        // Frame running code 40; strobe 45, then reset mid-pulse.
        chk("pre_rst_applied", 32'(DutyApplied), 32'd40);
        chk("pre_rst_pwm",     32'(PwmOut),      32'd1);
        @(negedge Clk);
        DutyValid = 1'b1;
        DutyIn    = 6'd45;
        @(negedge Clk);
        DutyValid = 1'b0;
        chk("mid_pulse_pwm", 32'(PwmOut), 32'd1);
        Rest = 1'b1;
        @(negedge Clk);
        chk("mid_rst_pwm",     32'(PwmOut),      32'd0);
        chk("mid_rst_ps",      32'(PeriodStart), 32'd0);
        chk("mid_rst_applied", 32'(DutyApplied), 32'd20);
        chk("mid_rst_clamped", 32'(Clamped),     32'd0);
        @(negedge Clk);
        Rest = 1'b0;
        wait_ps("post_rst_marker");
        // The strobed 45 must have been discarded by reset.
        check_frame("post_rst", -1, 0, -1, 0, 30, 20, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
